logic_unit_pipe: RTL and testbench
==================================

// Module: logic_unit_pipe
// PURPOSE
//  Parametrised, pipelined bitwise logic unit; next generation of the team's 4-bit AND block.
//  Generalised in width and operation (AND/OR/XOR/NAND), with STAGES register stages and
//  valid/ready flow control on both sides.
//  An optional on-chip checker compares each result against a supplied expected value.
//  Sits between a vector source (file-driven bench or stimulus FIFO) and a result sink.
// PARAMETERS
//  WIDTH   4   operand/result width in bits (>=1)
//  STAGES  2   pipeline depth = latency in cycles (1..4)
//  CNT_W   16  width of vector and error counters
// PORTS
//  clk        in   1      clock; all state updates on the rising edge
//  rst_n      in   1      reset, asynchronous assert, active-low
//  clr        in   1      synchronous clear of vec_cnt/err_cnt/err_flag
//  in_valid   in   1      input vector valid
//  in_ready   out  1      unit can accept a vector this cycle
//  in_a       in   WIDTH  operand A
//  in_b       in   WIDTH  operand B
//  in_op      in   2      00 AND, 01 OR, 10 XOR, 11 NAND
//  in_exp     in   WIDTH  expected result (used only with checker)
//  out_valid  out  1      result valid
//  out_ready  in   1      sink accepts result
//  out_c      out  WIDTH  result
//  out_op     out  2      op that produced out_c
//  vec_cnt    out  CNT_W  accepted input vectors, saturating
//  err_cnt    out  CNT_W  checker mismatches, saturating
//  err_flag   out  1      sticky: any mismatch since reset/clr
// BEHAVIOUR
//  - Accept on in_valid&&in_ready. Result computed combinationally from in_a/in_b/in_op and
//    captured in stage 0.
//  - Result, op and exp travel together through stages 0..STAGES-1; last stage drives out_*.
//  - Each stage has a valid bit. Stage k advances when it is empty or stage k+1 advances;
//    the last stage advances on out_ready.
//  - in_ready = !v[0] || adv[0]. This is combinational from out_ready through the chain;
//    there are no bubbles.
//  - Latency exactly STAGES cycles with out_ready=1; throughput 1 vector/cycle.
//  - Backpressure: while out_valid && !out_ready, out_c/out_op hold stable.
//  - No vector is dropped or duplicated under backpressure; ordering is preserved.
//  - Pipe full + out_ready=0 -> in_ready=0. Accept and emit in the same cycle are legal when
//    full and out_ready=1.
//  - vec_cnt += 1 per accept; holds at 2^CNT_W-1 (no wrap).
//  - clr zeroes all counters and err_flag, has priority over a same-cycle increment, and
//    does not touch pipeline contents.
//  - Reset: all valid bits 0, data regs 0, out_valid=0, out_c=0, out_op=0, counters=0,
//    err_flag=0.
//    in_ready=1 after release.
//  - Reset mid-operation discards in-flight vectors; nothing is emitted after release until
//    new input.
// CONFIGURATION
//  LOGIC_UNIT_CHECK_EN defined:
//  - in_exp is piped with the data.
//  - On each output handshake, out_c != exp -> err_cnt += 1 (saturating) and err_flag <= 1.
//  LOGIC_UNIT_CHECK_EN undefined:
//  - in_exp is ignored and no exp registers are built.
//  - err_cnt is tied to 0 and err_flag to 0.
// TESTING
//  1 rst_n=0 mid-run -> out_valid=0 immediately; after release in_ready=1, vec_cnt=err_cnt=0.
//  2 STAGES=2: a=1100 b=1010 op=00 at cycle 0, out_ready=1 -> out_valid at cycle 2, out_c=1000.
//  3 16 back-to-back vectors cycling all 4 ops, out_ready=1 -> 16 ordered correct results on
//    consecutive cycles; vec_cnt=16.
//  4 Fill pipe, out_ready=0 for 5 cycles -> in_ready=0 after STAGES accepts, out_c stable;
//    release -> all results in order.
//  5 CHECK_EN: a=1111 b=0101 op=10 exp=0000 -> out_c=1010, err_cnt=1, err_flag=1; clr -> both 0.
//    Without macro: both stay 0.
//  6 CNT_W=4: 17 accepts -> vec_cnt=15 (saturated); clr with simultaneous accept -> vec_cnt=0.

Source files
------------

// File: rtl/logic_unit_pipe.sv
// Pipelined bitwise logic unit (AND/OR/XOR/NAND) with valid/ready flow control on both sides.
// Define LOGIC_UNIT_CHECK_EN to build the result checker that compares each output with in_exp.
module logic_unit_pipe #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_exp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_c,
  output logic [1:0]       out_op,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err_flag
);

  function automatic logic [WIDTH-1:0] logic_op(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic [1:0]       op);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~(a & b);
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return (&x) ? x : x + CNT_W'(1);
  endfunction

  logic [STAGES-1:0] v_q, v_d, adv;
  logic [WIDTH-1:0]  c_q  [STAGES];
  logic [WIDTH-1:0]  c_d  [STAGES];
  logic [1:0]        op_q [STAGES];
  logic [1:0]        op_d [STAGES];
  logic [CNT_W-1:0]  vec_q, vec_d;
  logic              accept, out_hs;

  // A stage may advance iff some stage at or after it is empty, or the sink takes the result.
  always_comb begin
    logic all_full;
    all_full = 1'b1;
    adv      = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      all_full = all_full & v_q[k];
      adv[k]   = !all_full || out_ready;
    end
  end

  assign in_ready  = adv[0];
  assign accept    = in_valid && adv[0];
  assign out_valid = v_q[STAGES-1];
  assign out_c     = c_q[STAGES-1];
  assign out_op    = op_q[STAGES-1];
  assign out_hs    = out_valid && out_ready;

  always_comb begin
    v_d  = v_q;
    c_d  = c_q;
    op_d = op_q;
    if (adv[0]) begin
      v_d[0]  = accept;
      c_d[0]  = logic_op(in_a, in_b, in_op);
      op_d[0] = in_op;
    end
    for (int k = 1; k < STAGES; k++) begin
      if (adv[k]) begin
        v_d[k]  = v_q[k-1];
        c_d[k]  = c_q[k-1];
        op_d[k] = op_q[k-1];
      end
    end
  end

  always_comb begin
    vec_d = vec_q;
    if (clr)         vec_d = '0;
    else if (accept) vec_d = sat_inc(vec_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q   <= '0;
      vec_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        c_q[k]  <= '0;
        op_q[k] <= '0;
      end
    end else begin
      v_q   <= v_d;
      vec_q <= vec_d;
      c_q   <= c_d;
      op_q  <= op_d;
    end
  end

  assign vec_cnt = vec_q;

`ifdef LOGIC_UNIT_CHECK_EN
  logic [WIDTH-1:0] exp_q [STAGES];
  logic [WIDTH-1:0] exp_d [STAGES];
  logic [CNT_W-1:0] err_q, err_d;
  logic             flag_q, flag_d;
  logic             mismatch;

  // Expected value shadows the result so it lines up at the output stage.
  always_comb begin
    exp_d = exp_q;
    if (adv[0]) exp_d[0] = in_exp;
    for (int k = 1; k < STAGES; k++) begin
      if (adv[k]) exp_d[k] = exp_q[k-1];
    end
  end

  assign mismatch = out_hs && (c_q[STAGES-1] != exp_q[STAGES-1]);

  always_comb begin
    err_d  = err_q;
    flag_d = flag_q;
    if (clr) begin
      err_d  = '0;
      flag_d = 1'b0;
    end else if (mismatch) begin
      err_d  = sat_inc(err_q);
      flag_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q  <= '0;
      flag_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) exp_q[k] <= '0;
    end else begin
      err_q  <= err_d;
      flag_q <= flag_d;
      exp_q  <= exp_d;
    end
  end

  assign err_cnt  = err_q;
  assign err_flag = flag_q;
`else
  logic unused_exp;
  assign unused_exp = ^{in_exp, out_hs};
  assign err_cnt    = '0;
  assign err_flag   = 1'b0;
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe: driver pushes expected results, monitor pops on output handshake.
// A second instance with CNT_W=4 shares the stimulus to exercise counter saturation.
module tb_logic_unit_pipe;
  localparam int WIDTH  = 4;
  localparam int STAGES = 2;
  localparam int CNT_W  = 16;
  localparam int SAT_W  = 4;
`ifdef LOGIC_UNIT_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n, clr, in_valid, out_ready;
  logic [WIDTH-1:0] in_a, in_b, in_exp;
  logic [1:0]       in_op;
  logic             in_ready, out_valid, err_flag;
  logic [WIDTH-1:0] out_c;
  logic [1:0]       out_op;
  logic [CNT_W-1:0] vec_cnt, err_cnt;
  logic             s_in_ready, s_out_valid, s_err_flag;
  logic [WIDTH-1:0] s_out_c;
  logic [1:0]       s_out_op;
  logic [SAT_W-1:0] s_vec_cnt, s_err_cnt;

  logic_unit_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_exp(in_exp),
    .out_valid(out_valid), .out_ready(out_ready), .out_c(out_c), .out_op(out_op),
    .vec_cnt(vec_cnt), .err_cnt(err_cnt), .err_flag(err_flag));

  logic_unit_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .CNT_W(SAT_W)) dut_sat (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_exp(in_exp),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_c(s_out_c), .out_op(s_out_op),
    .vec_cnt(s_vec_cnt), .err_cnt(s_err_cnt), .err_flag(s_err_flag));

  typedef struct {
    logic [WIDTH-1:0] c;
    logic [1:0]       op;
    bit               bad;
  } item_t;
  item_t sb[$];

  int checks   = 0;
  int failures = 0;
  int rdy_mode = 0;  // 0: always ready, 1: random, 2: stalled
  int pops     = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: evaluate each result bit from the op's truth table.
  function automatic logic [WIDTH-1:0] ref_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                              input logic [1:0] op);
    logic [WIDTH-1:0] r;
    bit table_row[4];
    for (int i = 0; i < WIDTH; i++) begin
      case (op)
        2'd0: table_row = '{0, 0, 0, 1};
        2'd1: table_row = '{0, 1, 1, 1};
        2'd2: table_row = '{0, 1, 1, 0};
        default: table_row = '{1, 1, 1, 0};
      endcase
      r[i] = table_row[{a[i], b[i]}];
    end
    return r;
  endfunction

  function automatic longint satv(input longint v, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  // One cycle of stimulus: drive at negedge, sample just before the next posedge.
  task automatic cycle_drive(input bit v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input logic [1:0] op, input logic [WIDTH-1:0] e, input bit c,
                             output bit accepted);
    item_t it;
    @(negedge clk);
    in_valid = v; in_a = a; in_b = b; in_op = op; in_exp = e; clr = c;
    #4;
    accepted = in_valid && in_ready;
    if (accepted) begin
      it.c   = ref_op(a, b, op);
      it.op  = op;
      it.bad = (e != it.c);
      sb.push_back(it);
    end
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cycle_drive(1'b0, '0, '0, 2'd0, '0, 1'b0, acc);
  endtask

  task automatic drain(input string name);
    int budget;
    budget = 0;
    while (sb.size() != 0 && budget < 60) begin
      idle(1);
      budget++;
    end
    idle(1);
    check(name, sb.size(), 0);
  endtask

  task automatic rand_vec(output logic [WIDTH-1:0] a, output logic [WIDTH-1:0] b,
                          output logic [1:0] op, output logic [WIDTH-1:0] e);
    a  = WIDTH'($urandom);
    b  = WIDTH'($urandom);
    op = 2'($urandom);
    e  = ref_op(a, b, op);
    if ($urandom_range(0, 7) == 0) e = e ^ WIDTH'($urandom_range(1, (1 << WIDTH) - 1));
  endtask

  // Monitor: scoreboard pops, hold-under-stall checks and counter model.
  initial begin : monitor
    longint mvec, merr;
    bit mflag, stall_prev, hs, acc, bad;
    logic [WIDTH-1:0] held_c;
    logic [1:0] held_op;
    item_t it;
    mvec = 0; merr = 0; mflag = 0; stall_prev = 0; held_c = '0; held_op = '0;
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      out_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
      #4;
      if (!rst_n) begin
        mvec = 0; merr = 0; mflag = 0; stall_prev = 0;
      end else begin
        check("vec_cnt", vec_cnt, satv(mvec, CNT_W));
        check("sat_vec_cnt", s_vec_cnt, satv(mvec, SAT_W));
        check("err_cnt", err_cnt, satv(merr, CNT_W));
        check("sat_err_cnt", s_err_cnt, satv(merr, SAT_W));
        check("err_flag", err_flag, mflag);
        if (stall_prev) begin
          check("hold_valid", out_valid, 1);
          check("hold_c", out_c, held_c);
          check("hold_op", out_op, held_op);
        end
        hs  = out_valid && out_ready;
        acc = in_valid && in_ready;
        bad = 1'b0;
        if (hs) begin
          if (sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_output: got out_c=%0d expected no output", out_c);
          end else begin
            it = sb.pop_front();
            check("out_c", out_c, it.c);
            check("out_op", out_op, it.op);
            bad = it.bad;
            pops++;
          end
        end
        stall_prev = out_valid && !out_ready;
        held_c  = out_c;
        held_op = out_op;
        if (clr) begin
          mvec = 0; merr = 0; mflag = 0;
        end else begin
          if (acc) mvec++;
          if (CHK && hs && bad) begin merr++; mflag = 1'b1; end
        end
      end
    end
  end

  initial begin : stim
    bit acc;
    int nacc, p0;
    logic [WIDTH-1:0] a, b, e;
    logic [1:0] op;
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; in_exp = '0;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_c", out_c, 0);
    check("rst_out_op", out_op, 0);
    @(negedge clk); #2 rst_n = 1'b1;
    #2;
    check("rst_in_ready", in_ready, 1);
    check("rst_vec_cnt", vec_cnt, 0);

    // Single vector latency
    cycle_drive(1'b1, 4'b1100, 4'b1010, 2'b00, 4'b1000, 1'b0, acc);
    check("lat_accept", acc, 1);
    idle(1);
    check("lat_cycle1_valid", out_valid, 0);
    idle(1);
    check("lat_cycle2_valid", out_valid, 1);
    check("lat_cycle2_c", out_c, 4'b1000);
    drain("lat_drain");

    // 16 back-to-back vectors over all ops, then a 17th, then clr with accept
    idle(1);
    cycle_drive(1'b0, '0, '0, 2'd0, '0, 1'b1, acc);
    p0 = pops; nacc = 0;
    for (int i = 0; i < 16; i++) begin
      a = WIDTH'($urandom); b = WIDTH'($urandom); op = 2'(i % 4);
      cycle_drive(1'b1, a, b, op, ref_op(a, b, op), 1'b0, acc);
      nacc += int'(acc);
    end
    check("b2b_accepts", nacc, 16);
    idle(STAGES);
    check("b2b_all_out", pops - p0, 16);
    check("b2b_vec_cnt", vec_cnt, 16);
    check("b2b_sat_vec_cnt", s_vec_cnt, 15);
    cycle_drive(1'b1, 4'b0011, 4'b0101, 2'b01, 4'b0111, 1'b0, acc);
    idle(1);
    check("acc17_vec_cnt", vec_cnt, 17);
    check("acc17_sat_vec_cnt", s_vec_cnt, 15);
    cycle_drive(1'b1, 4'b0110, 4'b0101, 2'b11, 4'b1011, 1'b1, acc);
    check("clr_acc_accepted", acc, 1);
    idle(1);
    check("clr_acc_vec_cnt", vec_cnt, 0);
    check("clr_acc_sat_vec_cnt", s_vec_cnt, 0);
    drain("b2b_drain");

    // Backpressure: pipe fills, then holds
    rdy_mode = 2;
    nacc = 0;
    for (int i = 0; i < 5; i++) begin
      rand_vec(a, b, op, e);
      cycle_drive(1'b1, a, b, op, e, 1'b0, acc);
      nacc += int'(acc);
    end
    check("bp_accepts", nacc, STAGES);
    check("bp_in_ready", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    rdy_mode = 0;
    drain("bp_drain");

    // Checker: deliberate mismatch, then clear
    cycle_drive(1'b0, '0, '0, 2'd0, '0, 1'b1, acc);
    cycle_drive(1'b1, 4'b1111, 4'b0101, 2'b10, 4'b0000, 1'b0, acc);
    drain("chk_drain");
    check("chk_err_cnt", err_cnt, CHK ? 1 : 0);
    check("chk_err_flag", err_flag, CHK ? 1 : 0);
    cycle_drive(1'b0, '0, '0, 2'd0, '0, 1'b1, acc);
    idle(1);
    check("chk_clr_err_cnt", err_cnt, 0);
    check("chk_clr_err_flag", err_flag, 0);

    // Random traffic with random backpressure
    rdy_mode = 1;
    for (int i = 0; i < 300; i++) begin
      rand_vec(a, b, op, e);
      cycle_drive($urandom_range(0, 3) != 0, a, b, op, e, $urandom_range(0, 40) == 0, acc);
    end

    // Reset in mid-flight
    @(negedge clk);
    #2 rst_n = 1'b0;
    in_valid = 1'b0; clr = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    sb.delete();
    @(negedge clk);
    @(negedge clk); #2 rst_n = 1'b1;
    #2;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_vec_cnt", vec_cnt, 0);
    check("midrst_err_cnt", err_cnt, 0);
    for (int i = 0; i < 4; i++) begin
      idle(1);
      check("midrst_quiet", out_valid, 0);
    end

    // More random traffic, then drain
    for (int i = 0; i < 200; i++) begin
      rand_vec(a, b, op, e);
      cycle_drive($urandom_range(0, 1) != 0, a, b, op, e, 1'b0, acc);
    end
    rdy_mode = 0;
    drain("final_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
